// File: rtl/gpu_cmd_packet_sequencer_if.sv
// GP0 word-stream interface for the command packet sequencer: upstream FIFO side
// (word/valid/ready) and downstream framed-word side with packet tags.
interface gpu_cmd_packet_sequencer_if;
  logic [31:0] i_word;
  logic        i_wordValid;
  logic        o_wordReady;
  logic [31:0] o_outWord;
  logic        o_outValid;
  logic        i_outReady;
  logic [1:0]  o_outKind;
  logic [4:0]  o_outIdx;
  logic        o_outLast;
  logic [7:0]  o_outCmd;
  logic        o_busy;

  modport slave (
    input  i_word, i_wordValid, i_outReady,
    output o_wordReady, o_outWord, o_outValid, o_outKind, o_outIdx, o_outLast,
           o_outCmd, o_busy
  );

  modport master (
    output i_word, i_wordValid, i_outReady,
    input  o_wordReady, o_outWord, o_outValid, o_outKind, o_outIdx, o_outLast,
           o_outCmd, o_busy
  );
endinterface

// File: rtl/gpu_cmd_packet_sequencer.sv
// Frames the raw GP0 word stream into tagged command packets (kind/idx/last).
// Optional macro GPU_CMDSEQ_STATS_EN adds o_pktCount, a count of completed packets.
module gpu_cmd_packet_sequencer #(
  parameter int MAX_POLYLINE_VERTS = 256,
  parameter int CNT_W              = 20
) (
  input logic                       i_clk,
  input logic                       i_rst,
  gpu_cmd_packet_sequencer_if.slave bus
`ifdef GPU_CMDSEQ_STATS_EN
  ,
  output logic [15:0]               o_pktCount
`endif
);

  localparam int VERT_W = $clog2(MAX_POLYLINE_VERTS + 1);

  typedef enum logic [1:0] {S_IDLE, S_PARAM, S_PLINE, S_CV_DATA} state_t;
  typedef enum logic [1:0] {K_CMD, K_PARAM, K_PAYLOAD, K_TERM} kind_t;

  state_t            r_state, w_state_nxt;
  logic [4:0]        r_remain, w_remain_nxt;
  logic [4:0]        r_idx, w_idx_nxt;
  logic [CNT_W-1:0]  r_data_cnt, w_data_cnt_nxt;
  logic [VERT_W-1:0] r_vert_cnt, w_vert_cnt_nxt;
  logic              r_grp_pos, w_grp_pos_nxt;
  logic              r_g, w_g_nxt;
  logic              r_is_cv, w_is_cv_nxt;

  logic [31:0]       r_out_word;
  logic              r_out_valid;
  logic [1:0]        r_out_kind;
  logic [4:0]        r_out_idx;
  logic              r_out_last;
  logic [7:0]        r_out_cmd;

  logic              w_word_ready, w_xfer;
  logic [7:0]        w_cmd;
  logic [4:0]        w_verts, w_hdr_len;
  logic              w_is_pline, w_is_cv;
  logic [10:0]       w_cv_w;
  logic [9:0]        w_cv_h;
  logic [20:0]       w_cv_area;
  logic [CNT_W-1:0]  w_cv_words;
  kind_t             w_kind;
  logic [4:0]        w_idx, w_idx_inc;
  logic              w_last, w_term, w_grp_end;

  assign w_word_ready = !r_out_valid | bus.i_outReady;
  assign w_xfer       = bus.i_wordValid & w_word_ready;
  assign w_cmd        = bus.i_word[31:24];
  assign w_idx_inc    = (r_idx == 5'd31) ? r_idx : r_idx + 5'd1;

  // CPU->VRAM size word: zero width/height encode the maximum extent.
  assign w_cv_w     = (bus.i_word[9:0] == 10'd0) ? 11'd1024 : {1'b0, bus.i_word[9:0]};
  assign w_cv_h     = (bus.i_word[24:16] == 9'd0) ? 10'd512 : {1'b0, bus.i_word[24:16]};
  assign w_cv_area  = 21'(w_cv_w) * 21'(w_cv_h);
  assign w_cv_words = CNT_W'((w_cv_area + 21'd1) >> 1);

  // Header length decode of the command byte.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_verts    = w_cmd[3] ? 5'd4 : 5'd3;
    w_hdr_len  = 5'd1;
    w_is_pline = 1'b0;
    w_is_cv    = 1'b0;
    case (w_cmd[7:5])
      3'b000: w_hdr_len = (w_cmd == 8'h02) ? 5'd3 : 5'd1;
      3'b001: w_hdr_len = 5'd1 + (w_cmd[2] ? {w_verts[3:0], 1'b0} : w_verts)
                        + (w_cmd[4] ? w_verts - 5'd1 : 5'd0);
      3'b010: begin
        w_is_pline = w_cmd[3];
        w_hdr_len  = w_cmd[3] ? 5'd2 : (w_cmd[4] ? 5'd4 : 5'd3);
      end
      3'b011: w_hdr_len = 5'd2 + {4'd0, w_cmd[2]} + {4'd0, w_cmd[4:3] == 2'b00};
      3'b100: w_hdr_len = 5'd4;
      3'b101: begin
        w_hdr_len = 5'd3;
        w_is_cv   = 1'b1;
      end
      3'b110: w_hdr_len = 5'd3;
      default: w_hdr_len = 5'd1;
    endcase
  end

  // Output decode: tags for the word being accepted this cycle.
  always_comb begin
    w_kind    = K_CMD;
    w_idx     = r_idx;
    w_last    = 1'b0;
    w_term    = 1'b0;
    w_grp_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idx  = 5'd0;
        w_last = (w_hdr_len == 5'd1);
      end
      S_PARAM: begin
        w_kind = K_PARAM;
        w_last = (r_remain == 5'd1) && !r_is_cv;
      end
      S_CV_DATA: begin
        w_kind = K_PAYLOAD;
        w_last = (r_data_cnt == CNT_W'(1));
      end
      S_PLINE: begin
        w_term    = (r_vert_cnt >= VERT_W'(2)) && !r_grp_pos
                  && ((bus.i_word & 32'hF000_F000) == 32'h5000_5000);
        w_grp_end = (r_vert_cnt == '0) || (r_grp_pos == r_g);
        if (w_term) begin
          w_kind = K_TERM;
          w_last = 1'b1;
        end else begin
          w_kind = K_PARAM;
          w_last = w_grp_end && (r_vert_cnt == VERT_W'(MAX_POLYLINE_VERTS - 1));
        end
      end
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_remain_nxt   = r_remain;
    w_idx_nxt      = r_idx;
    w_data_cnt_nxt = r_data_cnt;
    w_vert_cnt_nxt = r_vert_cnt;
    w_grp_pos_nxt  = r_grp_pos;
    w_g_nxt        = r_g;
    w_is_cv_nxt    = r_is_cv;
    if (w_xfer) begin
      case (r_state)
        S_IDLE: if (w_hdr_len != 5'd1) begin
          w_state_nxt    = w_is_pline ? S_PLINE : S_PARAM;
          w_remain_nxt   = w_hdr_len - 5'd1;
          w_idx_nxt      = 5'd1;
          w_vert_cnt_nxt = '0;
          w_grp_pos_nxt  = 1'b0;
          w_g_nxt        = w_cmd[4];
          w_is_cv_nxt    = w_is_cv;
        end
        S_PARAM: begin
          w_remain_nxt = r_remain - 5'd1;
          w_idx_nxt    = w_idx_inc;
          if (r_remain == 5'd1) begin
            if (r_is_cv) begin
              w_state_nxt    = S_CV_DATA;
              w_data_cnt_nxt = w_cv_words;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_CV_DATA: begin
          w_data_cnt_nxt = r_data_cnt - CNT_W'(1);
          w_idx_nxt      = w_idx_inc;
          if (w_last) w_state_nxt = S_IDLE;
        end
        S_PLINE: begin
          w_idx_nxt = w_idx_inc;
          if (w_term || w_last) begin
            w_state_nxt = S_IDLE;
          end else if (w_grp_end) begin
            w_vert_cnt_nxt = r_vert_cnt + VERT_W'(1);
            w_grp_pos_nxt  = 1'b0;
          end else begin
            w_grp_pos_nxt = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_remain   <= '0;
      r_idx      <= '0;
      r_data_cnt <= '0;
      r_vert_cnt <= '0;
      r_grp_pos  <= 1'b0;
      r_g        <= 1'b0;
      r_is_cv    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_remain   <= w_remain_nxt;
      r_idx      <= w_idx_nxt;
      r_data_cnt <= w_data_cnt_nxt;
      r_vert_cnt <= w_vert_cnt_nxt;
      r_grp_pos  <= w_grp_pos_nxt;
      r_g        <= w_g_nxt;
      r_is_cv    <= w_is_cv_nxt;
    end
  end

  // Single output register stage; fields hold while stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_kind  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_out_cmd   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_word  <= bus.i_word;
      r_out_kind  <= w_kind;
      r_out_idx   <= w_idx;
      r_out_last  <= w_last;
      if (r_state == S_IDLE) r_out_cmd <= w_cmd;
    end else if (bus.i_outReady) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.o_wordReady = w_word_ready;
  assign bus.o_outWord   = r_out_word;
  assign bus.o_outValid  = r_out_valid;
  assign bus.o_outKind   = r_out_kind;
  assign bus.o_outIdx    = r_out_idx;
  assign bus.o_outLast   = r_out_last;
  assign bus.o_outCmd    = r_out_cmd;
  assign bus.o_busy      = (r_state != S_IDLE) | r_out_valid;

`ifdef GPU_CMDSEQ_STATS_EN
  logic [15:0] r_pkt_count;
  always_ff @(posedge i_clk) begin
    if (i_rst) r_pkt_count <= '0;
    else if (r_out_valid & bus.i_outReady & r_out_last) r_pkt_count <= r_pkt_count + 16'd1;
  end
  assign o_pktCount = r_pkt_count;
`endif

endmodule

// File: tb/tb_gpu_cmd_packet_sequencer.sv
// Scoreboard bench for gpu_cmd_packet_sequencer: directed packets push expected
// tags into a queue; a negedge monitor pops and compares each transferred output.
module tb_gpu_cmd_packet_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpu_cmd_packet_sequencer_if bus();
`ifdef GPU_CMDSEQ_STATS_EN
  logic [15:0] pkt_count;
`endif

  gpu_cmd_packet_sequencer dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef GPU_CMDSEQ_STATS_EN
    ,
    .o_pktCount (pkt_count)
`endif
  );

  typedef struct {
    logic [31:0] w;
    logic [1:0]  k;
    logic [4:0]  idx;
    logic        last;
    logic [7:0]  cmd;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every word that downstream accepts.
  always @(negedge clk) begin
    exp_t e;
    if (bus.o_outValid === 1'b1 && bus.i_outReady === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got word %h with no expected entry", bus.o_outWord);
      end else begin
        e = sb_q.pop_front();
        check("out_word", bus.o_outWord, e.w);
        check("out_kind", 32'(bus.o_outKind), 32'(e.k));
        check("out_idx", 32'(bus.o_outIdx), 32'(e.idx));
        check("out_last", 32'(bus.o_outLast), 32'(e.last));
        check("out_cmd", 32'(bus.o_outCmd), 32'(e.cmd));
      end
    end
  end

  task automatic push_exp(input logic [31:0] w, input logic [1:0] k, input logic [4:0] idx,
                          input logic last, input logic [7:0] cmd);
    exp_t e;
    e.w = w; e.k = k; e.idx = idx; e.last = last; e.cmd = cmd;
    sb_q.push_back(e);
  endtask

  // Presents one word until accepted, then checks the 1-cycle output latency.
  task automatic drive(input logic [31:0] w);
    logic rdy;
    bit   done = 1'b0;
    bus.i_word      = w;
    bus.i_wordValid = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      rdy = bus.o_wordReady;
      @(posedge clk);
      #2;
      done = rdy;
    end
    bus.i_wordValid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: word %h not accepted within 200 cycles", w);
    end else begin
      check("lat_valid", 32'(bus.o_outValid), 32'd1);
      check("lat_word", bus.o_outWord, w);
    end
  endtask

  task automatic send(input logic [31:0] w, input logic [1:0] k, input logic [4:0] idx,
                      input logic last, input logic [7:0] cmd);
    push_exp(w, k, idx, last, cmd);
    drive(w);
  endtask

  // Command word followed by n-1 plain parameter words.
  task automatic hdr_pkt(input logic [31:0] cw, input int n);
    logic [7:0] c;
    c = cw[31:24];
    send(cw, 2'd0, 5'd0, n == 1, c);
    for (int i = 1; i < n; i++) send(32'h0000_1000 + 32'(i), 2'd1, 5'(i), i == n - 1, c);
  endtask

  task automatic one_word_pkt(input logic [31:0] cw);
    hdr_pkt(cw, 1);
    check("busy_during", 32'(bus.o_busy), 32'd1);
    @(posedge clk);
    #2;
    check("busy_after", 32'(bus.o_busy), 32'd0);
  endtask

  logic [31:0] pk_cmd [12] = '{32'h3800_0000, 32'h2000_0000, 32'h2400_0000, 32'h3C00_0000,
                               32'h6000_0000, 32'h6400_0000, 32'h6800_0000, 32'h7C00_0000,
                               32'h5000_0000, 32'h0200_0000, 32'h8000_0000, 32'hC000_0000};
  int          pk_len [12] = '{8, 4, 7, 12, 3, 4, 2, 3, 4, 3, 4, 3};

  initial begin
    bit drained = 1'b0;
    rst             = 1'b1;
    bus.i_word      = '0;
    bus.i_wordValid = 1'b0;
    bus.i_outReady  = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 32'(bus.o_outValid), 32'd0);
    check("rst_word", bus.o_outWord, 32'd0);
    check("rst_kind_idx_last", {25'd0, bus.o_outKind, bus.o_outIdx}, 32'd0);
    check("rst_last", 32'(bus.o_outLast), 32'd0);
    check("rst_cmd", 32'(bus.o_outCmd), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #2;

    // Header-only packets of every decoded class.
    for (int p = 0; p < 12; p++) hdr_pkt(pk_cmd[p], pk_len[p]);

    one_word_pkt(32'hE100_0123);
    one_word_pkt(32'h0000_0000);
    one_word_pkt(32'h1F00_0000);

    // CPU->VRAM 3x3: 5 payload words, then a fresh command.
    send(32'hA000_0000, 2'd0, 5'd0, 1'b0, 8'hA0);
    send(32'h0000_0000, 2'd1, 5'd1, 1'b0, 8'hA0);
    send(32'h0003_0003, 2'd1, 5'd2, 1'b0, 8'hA0);
    for (int i = 0; i < 5; i++) send(32'h5000_5000 + 32'(i), 2'd2, 5'(3 + i), i == 4, 8'hA0);
    send(32'hE300_0000, 2'd0, 5'd0, 1'b1, 8'hE3);

    // Flat polyline; terminator pattern as 2nd vertex is ordinary data.
    send(32'h48FF_0000, 2'd0, 5'd0, 1'b0, 8'h48);
    send(32'h0010_0010, 2'd1, 5'd1, 1'b0, 8'h48);
    send(32'h5000_5000, 2'd1, 5'd2, 1'b0, 8'h48);
    send(32'h0030_0030, 2'd1, 5'd3, 1'b0, 8'h48);
    send(32'h5555_5555, 2'd3, 5'd4, 1'b1, 8'h48);

    // Shaded polyline: groups are V1, (C2,V2), (C3,V3), then terminator.
    send(32'h5800_00FF, 2'd0, 5'd0, 1'b0, 8'h58);
    send(32'h0010_0010, 2'd1, 5'd1, 1'b0, 8'h58);
    send(32'h5000_5000, 2'd1, 5'd2, 1'b0, 8'h58);
    send(32'h0020_0020, 2'd1, 5'd3, 1'b0, 8'h58);
    send(32'h0000_FF00, 2'd1, 5'd4, 1'b0, 8'h58);
    send(32'h5000_5000, 2'd1, 5'd5, 1'b0, 8'h58);
    send(32'h5FFF_5FFF, 2'd3, 5'd6, 1'b1, 8'h58);

    // Polyline vertex cap: 256th vertex ends the packet, idx saturates at 31.
    send(32'h4800_0000, 2'd0, 5'd0, 1'b0, 8'h48);
    for (int v = 1; v <= 256; v++)
      send({16'(v), 16'(v)}, 2'd1, (v > 31) ? 5'd31 : 5'(v), v == 256, 8'h48);
    send(32'hE100_0000, 2'd0, 5'd0, 1'b1, 8'hE1);

    // Backpressure mid-packet with a word waiting.
    send(32'h2000_0000, 2'd0, 5'd0, 1'b0, 8'h20);
    send(32'h0001_0001, 2'd1, 5'd1, 1'b0, 8'h20);
    bus.i_outReady  = 1'b0;
    bus.i_word      = 32'h0002_0002;
    bus.i_wordValid = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #2;
      check("bp_ready", 32'(bus.o_wordReady), 32'd0);
      check("bp_valid", 32'(bus.o_outValid), 32'd1);
      check("bp_word", bus.o_outWord, 32'h0001_0001);
      check("bp_idx", 32'(bus.o_outIdx), 32'd1);
    end
    bus.i_outReady = 1'b1;
    push_exp(32'h0002_0002, 2'd1, 5'd2, 1'b0, 8'h20);
    drive(32'h0002_0002);
    send(32'h0003_0003, 2'd1, 5'd3, 1'b1, 8'h20);

    // Reset in the middle of a CPU->VRAM payload (4x2 -> 4 words, 2 sent).
    send(32'hA000_0000, 2'd0, 5'd0, 1'b0, 8'hA0);
    send(32'h0000_0000, 2'd1, 5'd1, 1'b0, 8'hA0);
    send(32'h0002_0004, 2'd1, 5'd2, 1'b0, 8'hA0);
    send(32'h1111_1111, 2'd2, 5'd3, 1'b0, 8'hA0);
    send(32'h2222_2222, 2'd2, 5'd4, 1'b0, 8'hA0);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("mid_rst_valid", 32'(bus.o_outValid), 32'd0);
    check("mid_rst_word", bus.o_outWord, 32'd0);
    check("mid_rst_tags", {24'd0, bus.o_outLast, bus.o_outKind, bus.o_outIdx}, 32'd0);
    check("mid_rst_cmd", 32'(bus.o_outCmd), 32'd0);
    check("mid_rst_busy", 32'(bus.o_busy), 32'd0);
    check("mid_rst_sb_empty", 32'(sb_q.size()), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #2;
    send(32'hE200_0000, 2'd0, 5'd0, 1'b1, 8'hE2);

    for (int c = 0; c < 50 && !drained; c++) begin
      @(posedge clk);
      #2;
      drained = (sb_q.size() == 0) && !bus.o_busy;
    end
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    check("final_busy", 32'(bus.o_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
